// File: rtl/cache_data_bank.sv
// Set-associative cache data bank: byte-enabled CPU word writes, registered all-ways
// read (1-cycle latency), and a line-fill engine that streams a whole line into one way/set.
module cache_data_bank #(
    parameter int WIDTH      = 8,
    parameter int WAYS       = 4,
    parameter int TOTAL_SIZE = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_en,
    input  logic [$clog2(TOTAL_SIZE/WAYS)-1:0] rd_index,
    input  logic [$clog2(LINE_WORDS)-1:0]   rd_offset,
    output logic                            rd_valid,
    output logic [WAYS*WIDTH-1:0]           rd_data,
    input  logic                            wr_en,
    input  logic [$clog2(WAYS)-1:0]         wr_way,
    input  logic [$clog2(TOTAL_SIZE/WAYS)-1:0] wr_index,
    input  logic [$clog2(LINE_WORDS)-1:0]   wr_offset,
    input  logic [WIDTH-1:0]                wr_data,
    input  logic [WIDTH/8-1:0]              wr_be,
    input  logic                            fill_start,
    input  logic [$clog2(WAYS)-1:0]         fill_way,
    input  logic [$clog2(TOTAL_SIZE/WAYS)-1:0] fill_index,
    input  logic                            fill_valid,
    input  logic [WIDTH-1:0]                fill_data,
    output logic                            fill_ready,
    output logic                            fill_done,
    output logic                            busy
);
    localparam int SETS = TOTAL_SIZE / WAYS;
    localparam int IW   = $clog2(SETS);
    localparam int OW   = $clog2(LINE_WORDS);
    localparam int WW   = $clog2(WAYS);
    localparam int NB   = WIDTH / 8;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t           r_state;
    logic [WW-1:0]    r_fill_way;
    logic [IW-1:0]    r_fill_index;
    logic [OW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_fill_ready;
    logic             r_fill_done;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_mem [WAYS][SETS][LINE_WORDS];

    logic w_cpu_ok;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_fill_wr;

    // The CPU port is open only in IDLE, including the cycle a fill is started.
    assign w_cpu_ok  = (r_state == IDLE);
    assign w_rd_acc  = rd_en & w_cpu_ok;
    assign w_wr_acc  = wr_en & w_cpu_ok;
    assign w_fill_wr = (r_state == FILL) & fill_valid;

    assign rd_valid   = r_rd_valid;
    assign fill_ready = r_fill_ready;
    assign fill_done  = r_fill_done;
    assign busy       = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_fill_way   <= '0;
            r_fill_index <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_fill_ready <= 1'b0;
            r_fill_done  <= 1'b0;
        end else begin
            r_fill_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (fill_start) begin
                        r_state      <= FILL;
                        r_fill_way   <= fill_way;
                        r_fill_index <= fill_index;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_fill_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (fill_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        // Line sizes are powers of two, so all-ones marks the last word.
                        if (&r_cnt) begin
                            r_state      <= DONE;
                            r_fill_ready <= 1'b0;
                            r_fill_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_fill_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    for (int o = 0; o < LINE_WORDS; o++)
                        r_mem[w][s][o] <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                for (int b = 0; b < NB; b++)
                    if (wr_be[b])
                        r_mem[wr_way][wr_index][wr_offset][8*b +: 8] <= wr_data[8*b +: 8];
            end
            if (w_fill_wr)
                r_mem[r_fill_way][r_fill_index][r_cnt] <= fill_data;
        end
    end

    // One read register per way; they see pre-write contents on a same-cycle collision.
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [WIDTH-1:0] r_word;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_word <= '0;
                else if (w_rd_acc)
                    r_word <= r_mem[gi][rd_index][rd_offset];
            end
            assign rd_data[gi*WIDTH +: WIDTH] = r_word;
        end
    endgenerate

endmodule

// File: tb/tb_cache_data_bank.sv
// Bench for cache_data_bank (WIDTH=16): directed cases plus randomized CPU/fill traffic
// compared against an array model of the cache contents.
module tb_cache_data_bank;
    localparam int WIDTH = 16, WAYS = 4, TOTAL = 16, LW = 4, SETS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [1:0]  rd_index, rd_offset;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [1:0]  wr_way, wr_index, wr_offset;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        fill_start;
    logic [1:0]  fill_way, fill_index;
    logic        fill_valid;
    logic [15:0] fill_data;
    logic        fill_ready, fill_done, busy;

    cache_data_bank #(.WIDTH(WIDTH), .WAYS(WAYS), .TOTAL_SIZE(TOTAL), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_index(rd_index), .rd_offset(rd_offset),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_en(wr_en), .wr_way(wr_way), .wr_index(wr_index), .wr_offset(wr_offset),
        .wr_data(wr_data), .wr_be(wr_be),
        .fill_start(fill_start), .fill_way(fill_way), .fill_index(fill_index),
        .fill_valid(fill_valid), .fill_data(fill_data),
        .fill_ready(fill_ready), .fill_done(fill_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_mem [WAYS][SETS][LW];
    logic [63:0] exp_rd;

    // Pending CPU request of the current cycle.
    bit          p_rd, p_wr;
    int          p_ri, p_ro, p_ww, p_wi, p_wo;
    logic [15:0] p_wd;
    logic [1:0]  p_be;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_line(input int s, input int o);
        logic [63:0] v;
        for (int w = 0; w < WAYS; w++) v[w*16 +: 16] = m_mem[w][s][o];
        return v;
    endfunction

    task automatic model_clear();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                for (int o = 0; o < LW; o++) m_mem[w][s][o] = '0;
        exp_rd = '0;
    endtask

    task automatic cpu_set(input bit rd, input int ri, input int ro, input bit wr, input int ww,
                           input int wi, input int wo, input logic [15:0] wd, input logic [1:0] be);
        p_rd = rd; p_ri = ri; p_ro = ro; p_wr = wr; p_ww = ww; p_wi = wi; p_wo = wo;
        p_wd = wd; p_be = be;
        rd_en = rd; rd_index = 2'(ri); rd_offset = 2'(ro);
        wr_en = wr; wr_way = 2'(ww); wr_index = 2'(wi); wr_offset = 2'(wo);
        wr_data = wd; wr_be = be;
    endtask

    task automatic cpu_idle();
        cpu_set(0, 0, 0, 0, 0, 0, 0, 16'h0, 2'b00);
    endtask

    task automatic cpu_rand();
        cpu_set($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 16'($urandom), 2'($urandom_range(0, 3)));
    endtask

    // Resolve the request that was presented on the edge just passed.
    task automatic cpu_post(input bit acc);
        if (acc && p_rd) exp_rd = model_line(p_ri, p_ro);
        check("rd_valid", 64'(rd_valid), 64'(acc && p_rd));
        check("rd_data", rd_data, exp_rd);
        if (acc && p_wr)
            for (int b = 0; b < 2; b++)
                if (p_be[b]) m_mem[p_ww][p_wi][p_wo][8*b +: 8] = p_wd[8*b +: 8];
    endtask

    task automatic read_all();
        for (int s = 0; s < SETS; s++)
            for (int o = 0; o < LW; o++) begin
                cpu_set(1, s, o, 0, 0, 0, 0, 16'h0, 2'b00);
                tick();
                cpu_post(1);
            end
        cpu_idle();
    endtask

    // directed: words 0x10.. with a 2-cycle stall after word 1 and a read every FILL cycle.
    // abort_after >= 0 asserts rst once that many words have been accepted.
    task automatic run_fill(input int way, input int idx, input bit directed, input int abort_after);
        logic [15:0] words [LW];
        int k, stalls, cycles;
        bit v;
        for (int i = 0; i < LW; i++) words[i] = directed ? 16'(16'h10 + i) : 16'($urandom);
        if (directed) cpu_idle(); else cpu_rand();
        fill_start = 1'b1; fill_way = 2'(way); fill_index = 2'(idx);
        tick();
        cpu_post(1);
        check("busy_start", 64'(busy), 64'd1);
        check("ready_start", 64'(fill_ready), 64'd1);
        k = 0; stalls = 0; cycles = 0;
        while (k < LW) begin
            if (directed) cpu_set(1, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, 0, 16'h0, 2'b00);
            else cpu_rand();
            fill_start = 1'($urandom_range(0, 1));
            fill_way = 2'($urandom); fill_index = 2'($urandom);
            if (directed) begin
                v = !(k == 2 && stalls < 2);
                if (!v) stalls++;
            end else v = ($urandom_range(0, 2) != 0);
            fill_valid = v; fill_data = v ? words[k] : 16'($urandom);
            tick();
            cpu_post(0);
            if (v) begin
                m_mem[way][idx][k] = words[k];
                k++;
            end
            check("fill_busy", 64'(busy), 64'd1);
            check("fill_done", 64'(fill_done), 64'(k == LW));
            check("fill_ready", 64'(fill_ready), 64'(k != LW));
            cycles++;
            if (cycles > 200) begin
                check("fill_timeout", 64'(cycles), 64'd200);
                break;
            end
            if (abort_after >= 0 && k == abort_after) begin
                fill_valid = 1'b0; fill_start = 1'b0; cpu_idle();
                rst = 1'b1;
                #1;
                model_clear();
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_ready", 64'(fill_ready), 64'd0);
                check("rst_done", 64'(fill_done), 64'd0);
                check("rst_rd_valid", 64'(rd_valid), 64'd0);
                check("rst_rd_data", rd_data, 64'd0);
                tick();
                rst = 1'b0;
                tick();
                check("post_rst_done", 64'(fill_done), 64'd0);
                check("post_rst_busy", 64'(busy), 64'd0);
                return;
            end
        end
        fill_valid = 1'b0; fill_start = 1'b0;
        if (directed) cpu_set(1, idx, 0, 0, 0, 0, 0, 16'h0, 2'b00); else cpu_rand();
        tick();
        cpu_post(0);
        check("after_busy", 64'(busy), 64'd0);
        check("after_done", 64'(fill_done), 64'd0);
        check("after_ready", 64'(fill_ready), 64'd0);
        cpu_idle();
    endtask

    initial begin
        rst = 1'b1;
        fill_start = 1'b0; fill_way = '0; fill_index = '0; fill_valid = 1'b0; fill_data = '0;
        cpu_idle();
        model_clear();
        tick(); tick();
        rst = 1'b0;
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_rd_data", rd_data, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(fill_ready), 64'd0);
        check("reset_done", 64'(fill_done), 64'd0);

        // Read after reset, then rd_valid must drop while rd_data holds.
        cpu_set(1, 2, 1, 0, 0, 0, 0, 16'h0, 2'b00); tick(); cpu_post(1);
        cpu_idle(); tick(); cpu_post(1);

        // Byte write and readback.
        cpu_set(0, 0, 0, 1, 3, 1, 2, 16'h00A5, 2'b01); tick(); cpu_post(1);
        cpu_set(1, 1, 2, 0, 0, 0, 0, 16'h0, 2'b00); tick(); cpu_post(1);
        check("wr_a5", rd_data, 64'h00A5_0000_0000_0000);

        // Byte-enable merge.
        cpu_set(0, 0, 0, 1, 0, 0, 0, 16'h1234, 2'b11); tick(); cpu_post(1);
        cpu_set(0, 0, 0, 1, 0, 0, 0, 16'hFFFF, 2'b01); tick(); cpu_post(1);
        cpu_set(0, 0, 0, 1, 0, 0, 0, 16'h0BAD, 2'b00); tick(); cpu_post(1);
        cpu_set(1, 0, 0, 0, 0, 0, 0, 16'h0, 2'b00); tick(); cpu_post(1);
        check("be_merge", 64'(rd_data[15:0]), 64'h12FF);

        // Same-cycle read/write returns old data.
        cpu_set(1, 1, 2, 1, 3, 1, 2, 16'h005A, 2'b01); tick(); cpu_post(1);
        check("rw_old", 64'(rd_data[63:48]), 64'h00A5);
        cpu_set(1, 1, 2, 0, 0, 0, 0, 16'h0, 2'b00); tick(); cpu_post(1);
        check("rw_new", 64'(rd_data[63:48]), 64'h005A);
        cpu_idle();

        // Directed fill of way 1, set 3.
        run_fill(1, 3, 1'b1, -1);
        for (int o = 0; o < LW; o++) begin
            cpu_set(1, 3, o, 0, 0, 0, 0, 16'h0, 2'b00); tick(); cpu_post(1);
            check("fill_word", 64'(rd_data[31:16]), 64'(16'h10 + o));
        end
        cpu_idle();

        // Reset mid-fill, storage must read back zero, then a fresh fill completes.
        run_fill(2, 1, 1'b0, 2);
        read_all();
        run_fill(0, 2, 1'b0, -1);
        read_all();

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 11) == 0) begin
                run_fill($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, -1);
            end else begin
                cpu_rand(); tick(); cpu_post(1);
            end
        end
        cpu_idle();
        read_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
